// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM access port between the audio cores
// (mixer, recorder, player), with a per-access timeout on each grant.
module sdram_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_REQ-1:0]          i_req_read,
   input  logic [NUM_REQ-1:0]          i_req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   i_req_writedata,
   output logic [DATA_W-1:0]           o_req_readdata,
   output logic [NUM_REQ-1:0]          o_req_finished,
   output logic                        o_sdram_read,
   output logic                        o_sdram_write,
   output logic [ADDR_W-1:0]           o_sdram_addr,
   output logic [DATA_W-1:0]           o_sdram_writedata,
   input  logic [DATA_W-1:0]           i_sdram_readdata,
   input  logic                        i_sdram_finished,
   output logic [NUM_REQ-1:0]          o_grant,
   output logic                        o_busy,
   output logic                        o_timeout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TC_W  = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state;
   state_t             next_state;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   last_idx;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;
   logic [TC_W-1:0]    tcount;
   logic [NUM_REQ-1:0] req;
   logic               timeout_hit;

   assign req = i_req_read | i_req_write;

   // Circular search starting just after the last served requester.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand     = (int'(last_idx) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!pick_valid && req[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   assign timeout_hit = (state == BUSY) && !i_sdram_finished &&
                        (tcount == TC_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         grant_idx <= '0;
         last_idx  <= IDX_W'(NUM_REQ - 1);
         tcount    <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE) begin
            if (pick_valid) begin
               grant_idx <= pick_idx;
               tcount    <= '0;
            end
         end else if (i_sdram_finished || timeout_hit) begin
            last_idx <= grant_idx;
         end else begin
            tcount <= tcount + 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (pick_valid) next_state = BUSY;
         BUSY: if (i_sdram_finished || timeout_hit) next_state = IDLE;
      endcase
   end

   // A requester raising both strobes is treated as a write.
   always_comb begin
      o_sdram_read      = 1'b0;
      o_sdram_write     = 1'b0;
      o_sdram_addr      = '0;
      o_sdram_writedata = '0;
      o_grant           = '0;
      o_req_finished    = '0;
      if (state == BUSY) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
               o_grant[k]        = 1'b1;
               o_req_finished[k] = i_sdram_finished;
               o_sdram_write     = i_req_write[k];
               o_sdram_read      = i_req_read[k] & ~i_req_write[k];
               o_sdram_addr      = i_req_addr[k*ADDR_W +: ADDR_W];
               o_sdram_writedata = i_req_writedata[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign o_req_readdata = i_sdram_readdata;
   assign o_busy         = (state == BUSY);
   assign o_timeout      = timeout_hit;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: single access, contention, hog fairness,
// read/write collision, timeout and reset in the middle of an access.
module tb_sdram_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 23;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;

   logic                      clk;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_read;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_writedata;
   logic [DATA_W-1:0]         req_readdata;
   logic [NUM_REQ-1:0]        req_finished;
   logic                      sdram_read;
   logic                      sdram_write;
   logic [ADDR_W-1:0]         sdram_addr;
   logic [DATA_W-1:0]         sdram_writedata;
   logic [DATA_W-1:0]         sdram_readdata;
   logic                      sdram_finished;
   logic [NUM_REQ-1:0]        grant;
   logic                      busy;
   logic                      timeout;

   int n_vectors;
   int n_miscompares;

   sdram_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_req_read(req_read),
      .i_req_write(req_write),
      .i_req_addr(req_addr),
      .i_req_writedata(req_writedata),
      .o_req_readdata(req_readdata),
      .o_req_finished(req_finished),
      .o_sdram_read(sdram_read),
      .o_sdram_write(sdram_write),
      .o_sdram_addr(sdram_addr),
      .o_sdram_writedata(sdram_writedata),
      .i_sdram_readdata(sdram_readdata),
      .i_sdram_finished(sdram_finished),
      .o_grant(grant),
      .o_busy(busy),
      .o_timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int k, input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      req_read[k]                    = rd;
      req_write[k]                   = wr;
      req_addr[k*ADDR_W +: ADDR_W]   = addr;
      req_writedata[k*DATA_W +: DATA_W] = data;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      n_vectors++;
      assert (observed === expected) else begin
         n_miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      n_vectors      = 0;
      n_miscompares  = 0;
      rst_n          = 1'b0;
      req_read       = '0;
      req_write      = '0;
      req_addr       = '0;
      req_writedata  = '0;
      sdram_readdata = 32'hCAFEF00D;
      sdram_finished = 1'b0;

      // Reset state, readdata passes through regardless
      #2;
      check_output("reset_grant", 64'(grant), 64'h0);
      check_output("reset_busy", 64'(busy), 64'h0);
      check_output("reset_strobes", 64'({sdram_read, sdram_write}), 64'h0);
      check_output("reset_finished", 64'(req_finished), 64'h0);
      check_output("reset_timeout", 64'(timeout), 64'h0);
      check_output("reset_readdata", 64'(req_readdata), 64'hCAFEF00D);
      tick();
      rst_n = 1'b1;

      // Single requester: mixer reads 0x000100, finished 3 cycles after strobe
      tick();
      set_req(0, 1'b1, 1'b0, 23'h000100, 32'h0);
      settle();
      check_output("single_idle_grant", 64'(grant), 64'h0);
      tick();
      settle();
      check_output("single_grant", 64'(grant), 64'h1);
      check_output("single_read", 64'({sdram_read, sdram_write}), 64'h2);
      check_output("single_addr", 64'(sdram_addr), 64'h000100);
      check_output("single_busy", 64'(busy), 64'h1);
      tick();
      tick();
      settle();
      check_output("single_no_finish", 64'(req_finished), 64'h0);
      tick();
      sdram_finished = 1'b1;
      sdram_readdata = 32'hDEADBEEF;
      settle();
      check_output("single_finished", 64'(req_finished), 64'h1);
      check_output("single_data", 64'(req_readdata), 64'hDEADBEEF);
      tick();
      sdram_finished = 1'b0;
      set_req(0, 1'b0, 1'b0, 23'h0, 32'h0);
      settle();
      check_output("single_release", 64'(grant), 64'h0);
      check_output("single_release_busy", 64'(busy), 64'h0);

      // Contention from reset: order 0, 1, 2, then 0 again
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_req(0, 1'b1, 1'b0, 23'h000010, 32'h0);
      set_req(1, 1'b1, 1'b0, 23'h000020, 32'h0);
      set_req(2, 1'b1, 1'b0, 23'h000030, 32'h0);
      tick();
      sdram_finished = 1'b1;
      settle();
      check_output("cont_grant0", 64'(grant), 64'h1);
      check_output("cont_addr0", 64'(sdram_addr), 64'h000010);
      check_output("cont_fin0", 64'(req_finished), 64'h1);
      tick();
      sdram_finished = 1'b0;
      settle();
      check_output("cont_idle0", 64'(grant), 64'h0);
      tick();
      sdram_finished = 1'b1;
      settle();
      check_output("cont_grant1", 64'(grant), 64'h2);
      check_output("cont_addr1", 64'(sdram_addr), 64'h000020);
      check_output("cont_fin1", 64'(req_finished), 64'h2);
      tick();
      sdram_finished = 1'b0;
      set_req(1, 1'b0, 1'b0, 23'h0, 32'h0);
      tick();
      sdram_finished = 1'b1;
      settle();
      check_output("cont_grant2", 64'(grant), 64'h4);
      check_output("cont_addr2", 64'(sdram_addr), 64'h000030);
      check_output("cont_fin2", 64'(req_finished), 64'h4);
      tick();
      sdram_finished = 1'b0;
      set_req(2, 1'b0, 1'b0, 23'h0, 32'h0);
      tick();
      sdram_finished = 1'b1;
      settle();
      check_output("cont_grant0_again", 64'(grant), 64'h1);
      check_output("cont_fin0_again", 64'(req_finished), 64'h1);
      tick();
      sdram_finished = 1'b0;
      set_req(0, 1'b0, 1'b0, 23'h0, 32'h0);

      // Hog: mixer strobes continuously, recorder asks once
      tick();
      set_req(0, 1'b1, 1'b0, 23'h000A00, 32'h0);
      tick();
      set_req(1, 1'b0, 1'b1, 23'h000B00, 32'hA5A5A5A5);
      settle();
      check_output("hog_grant_mixer", 64'(grant), 64'h1);
      tick();
      sdram_finished = 1'b1;
      settle();
      check_output("hog_fin_mixer", 64'(req_finished), 64'h1);
      tick();
      sdram_finished = 1'b0;
      tick();
      sdram_finished = 1'b1;
      settle();
      check_output("hog_grant_rec", 64'(grant), 64'h2);
      check_output("hog_rec_write", 64'({sdram_read, sdram_write}), 64'h1);
      check_output("hog_rec_wdata", 64'(sdram_writedata), 64'hA5A5A5A5);
      check_output("hog_fin_rec", 64'(req_finished), 64'h2);
      tick();
      sdram_finished = 1'b0;
      set_req(1, 1'b0, 1'b0, 23'h0, 32'h0);
      tick();
      settle();
      check_output("hog_grant_mixer2", 64'(grant), 64'h1);
      sdram_finished = 1'b1;
      tick();
      sdram_finished = 1'b0;
      set_req(0, 1'b0, 1'b0, 23'h0, 32'h0);

      // Read+write collision on player
      tick();
      set_req(2, 1'b1, 1'b1, 23'h7FFFFF, 32'h12345678);
      tick();
      settle();
      check_output("coll_grant", 64'(grant), 64'h4);
      check_output("coll_strobes", 64'({sdram_read, sdram_write}), 64'h1);
      check_output("coll_addr", 64'(sdram_addr), 64'h7FFFFF);
      check_output("coll_wdata", 64'(sdram_writedata), 64'h12345678);
      sdram_finished = 1'b1;
      tick();
      sdram_finished = 1'b0;
      set_req(2, 1'b0, 1'b0, 23'h0, 32'h0);

      // Timeout: recorder granted at g, player waiting
      tick();
      set_req(1, 1'b1, 1'b0, 23'h000055, 32'h0);
      tick();
      set_req(2, 1'b1, 1'b0, 23'h000066, 32'h0);
      settle();
      check_output("to_grant_g", 64'(grant), 64'h2);
      check_output("to_quiet_g", 64'(timeout), 64'h0);
      repeat (6) tick();
      settle();
      check_output("to_quiet_g6", 64'(timeout), 64'h0);
      check_output("to_grant_g6", 64'(grant), 64'h2);
      tick();
      settle();
      check_output("to_pulse_g7", 64'(timeout), 64'h1);
      check_output("to_grant_g7", 64'(grant), 64'h2);
      check_output("to_nofin_g7", 64'(req_finished), 64'h0);
      tick();
      set_req(1, 1'b0, 1'b0, 23'h0, 32'h0);
      settle();
      check_output("to_idle_g8", 64'(grant), 64'h0);
      check_output("to_clear_g8", 64'(timeout), 64'h0);
      tick();
      settle();
      check_output("to_next_g9", 64'(grant), 64'h4);
      check_output("to_next_addr", 64'(sdram_addr), 64'h000066);
      repeat (6) tick();
      settle();
      check_output("to2_quiet_h6", 64'(timeout), 64'h0);
      tick();
      sdram_finished = 1'b1;
      settle();
      check_output("to2_no_pulse_h7", 64'(timeout), 64'h0);
      check_output("to2_fin_h7", 64'(req_finished), 64'h4);
      tick();
      sdram_finished = 1'b0;
      set_req(2, 1'b0, 1'b0, 23'h0, 32'h0);
      settle();
      check_output("to2_idle_h8", 64'(busy), 64'h0);

      // Reset in the middle of an access
      tick();
      set_req(1, 1'b1, 1'b0, 23'h000077, 32'h0);
      tick();
      settle();
      check_output("rst_busy_before", 64'(grant), 64'h2);
      rst_n = 1'b0;
      settle();
      check_output("rst_grant_drop", 64'(grant), 64'h0);
      check_output("rst_strobe_drop", 64'({sdram_read, sdram_write}), 64'h0);
      check_output("rst_busy_drop", 64'(busy), 64'h0);
      tick();
      rst_n          = 1'b1;
      sdram_finished = 1'b1;
      set_req(0, 1'b1, 1'b0, 23'h000011, 32'h0);
      set_req(2, 1'b1, 1'b0, 23'h000033, 32'h0);
      settle();
      check_output("rst_stale_finish", 64'(req_finished), 64'h0);
      tick();
      sdram_finished = 1'b0;
      settle();
      check_output("rst_first_winner", 64'(grant), 64'h1);
      check_output("rst_first_addr", 64'(sdram_addr), 64'h000011);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
